// File: rtl/fp64_mul_seq.sv
// Multi-cycle binary64 multiplier with an iterative shift-add mantissa datapath.
// Optional round-to-nearest-even via `define FP64_MUL_RNE_EN (default: truncation).
module fp64_mul_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);
    localparam int N = (53 + STEP - 1) / STEP;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_MUL, S_NORM, S_PACK, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [62:0]         r_a, r_b;
    logic                r_sign;
    logic [105:0]        r_ma, r_acc, w_pp;
    logic [55:0]         r_mb;
    logic signed [12:0]  r_e, w_pe, w_e0;
    logic [5:0]          r_cnt;
    logic [51:0]         r_frac, w_pf;
    logic [63:0]         r_res, w_spec_res;
    logic [10:0]         w_ea, w_eb;
    logic                w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic                w_zero_a, w_zero_b, w_special;
`ifdef FP64_MUL_RNE_EN
    logic                r_g, r_s;
    logic [64:0]         w_rnd;
`endif

    assign w_nan_a   = (r_a[62:52] == 11'h7FF) && (r_a[51:0] != '0);
    assign w_nan_b   = (r_b[62:52] == 11'h7FF) && (r_b[51:0] != '0);
    assign w_inf_a   = (r_a[62:52] == 11'h7FF) && (r_a[51:0] == '0);
    assign w_inf_b   = (r_b[62:52] == 11'h7FF) && (r_b[51:0] == '0);
    assign w_zero_a  = (r_a[62:0] == '0);
    assign w_zero_b  = (r_b[62:0] == '0);
    assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b
                     | w_zero_a | w_zero_b;

    // Subnormal operands use exponent 1 with a hidden bit of 0.
    assign w_ea = (r_a[62:52] == '0) ? 11'd1 : r_a[62:52];
    assign w_eb = (r_b[62:52] == '0) ? 11'd1 : r_b[62:52];
    assign w_e0 = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb})
                - 13'sd1023;

    always_comb begin
        w_spec_res = {r_sign, 63'b0};
        if (w_nan_a || w_nan_b)
            w_spec_res = 64'h7FF8000000000000;
        else if ((w_inf_a && w_zero_b) || (w_zero_a && w_inf_b))
            w_spec_res = 64'h7FF8000000000000;
        else if (w_inf_a || w_inf_b)
            w_spec_res = {r_sign, 11'h7FF, 52'b0};
    end

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < STEP; i++)
            if (r_mb[i]) w_pp = w_pp + (r_ma << i);
    end

    always_comb begin
`ifdef FP64_MUL_RNE_EN
        w_rnd = {r_e, r_frac};
        if (r_g && (r_s || r_frac[0])) w_rnd = w_rnd + 65'd1;
        w_pe = $signed(w_rnd[64:52]);
        w_pf = w_rnd[51:0];
`else
        w_pe = r_e;
        w_pf = r_frac;
`endif
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid) w_next = S_CHK;
            S_CHK:  w_next = w_special ? S_DONE : S_MUL;
            S_MUL:  if (r_cnt == '0) w_next = S_NORM;
            S_NORM: if (r_acc[105] || r_acc[104]) w_next = S_PACK;
            S_PACK: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sign <= 1'b0;
            r_ma   <= '0;
            r_mb   <= '0;
            r_acc  <= '0;
            r_e    <= '0;
            r_cnt  <= '0;
            r_frac <= '0;
            r_res  <= '0;
`ifdef FP64_MUL_RNE_EN
            r_g    <= 1'b0;
            r_s    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a    <= a[62:0];
                    r_b    <= b[62:0];
                    r_sign <= a[63] ^ b[63];
                end
                S_CHK: if (w_special) begin
                    r_res <= w_spec_res;
                end else begin
                    r_ma  <= {53'b0, (r_a[62:52] != '0), r_a[51:0]};
                    r_mb  <= {3'b0, (r_b[62:52] != '0), r_b[51:0]};
                    r_e   <= w_e0;
                    r_acc <= '0;
                    r_cnt <= 6'(N - 1);
                end
                S_MUL: begin
                    r_acc <= r_acc + w_pp;
                    r_ma  <= r_ma << STEP;
                    r_mb  <= r_mb >> STEP;
                    r_cnt <= r_cnt - 6'd1;
                end
                S_NORM: begin
                    if (r_acc[105]) begin
                        r_frac <= r_acc[104:53];
                        r_e    <= r_e + 13'sd1;
`ifdef FP64_MUL_RNE_EN
                        r_g    <= r_acc[52];
                        r_s    <= |r_acc[51:0];
`endif
                    end else if (r_acc[104]) begin
                        r_frac <= r_acc[103:52];
`ifdef FP64_MUL_RNE_EN
                        r_g    <= r_acc[51];
                        r_s    <= |r_acc[50:0];
`endif
                    end else begin
                        r_acc <= r_acc << 1;
                        r_e   <= r_e - 13'sd1;
                    end
                end
                S_PACK: begin
                    if (w_pe >= 13'sd2047)
                        r_res <= {r_sign, 11'h7FF, 52'b0};
                    else if (w_pe <= 13'sd0)
                        r_res <= {r_sign, 63'b0};
                    else
                        r_res <= {r_sign, w_pe[10:0], w_pf};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_res;
endmodule
